// File: rtl/fdiv_pkg.sv
// ============================================================================
// Module      : fdiv_pkg
// Description : Shared types and constants for the iterative FP divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIV   = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_class_t;

    localparam int FLAG_INVALID  = 4;
    localparam int FLAG_DIV0     = 3;
    localparam int FLAG_OVERFLOW = 2;
    localparam int FLAG_UNDERFLW = 1;
    localparam int FLAG_INEXACT  = 0;

    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;
    localparam int BF16_EXP_W = 8;
    localparam int BF16_MAN_W = 7;
    localparam int FP16_EXP_W = 5;
    localparam int FP16_MAN_W = 10;

    // Canonical quiet NaN {0, all-ones, 1, zeros}, right-aligned in 64 bits.
    function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = ((64'd1 << exp_w) - 64'd1) << man_w;
        v = v | (64'd1 << (man_w - 1));
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fdiv_unpack.sv
// ============================================================================
// Module      : fdiv_unpack
// Description : Splits an operand into sign, exponent, significand and class.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fdiv_unpack
    import fdiv_pkg::*;
#(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int DW    = 1 + EXP_W + MAN_W
) (
    input  logic [DW-1:0]    i_op,
    output logic             o_sign,
    output logic [EXP_W-1:0] o_exp,
    output logic [MAN_W:0]   o_sig,
    output fp_class_t        o_cls
);

    logic [MAN_W-1:0] w_frac;

    assign o_sign = i_op[DW-1];
    assign o_exp  = i_op[DW-2 -: EXP_W];
    assign w_frac = i_op[MAN_W-1:0];
    assign o_sig  = {1'b1, w_frac};

    // Zero exponent flushes to zero; subnormals are not represented.
    always_comb begin
        o_cls = CLS_NORM;
        if (o_exp == '0)
            o_cls = CLS_ZERO;
        else if (&o_exp)
            o_cls = (w_frac == '0) ? CLS_INF : CLS_NAN;
    end

endmodule

`default_nettype wire

// File: rtl/fdiv_iter.sv
// ============================================================================
// Module      : fdiv_iter
// Description : Multi-cycle radix-2 restoring FP divider, RNE rounding.
//               Define FDIV_ITER_FLAGS_EN to add the out_flags port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fdiv_iter
    import fdiv_pkg::*;
#(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int DW    = 1 + EXP_W + MAN_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_q
`ifdef FDIV_ITER_FLAGS_EN
    ,
    output logic [4:0]    out_flags
`endif
);

    localparam int c_CNT_W = $clog2(MAN_W + 4);
    localparam int c_EW    = EXP_W + 2;
    localparam logic [c_CNT_W-1:0]     c_CNT_LAST = c_CNT_W'(MAN_W + 2);
    localparam logic signed [c_EW-1:0] c_BIAS     = c_EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [c_EW-1:0] c_EXP_MAX  = c_EW'((1 << EXP_W) - 1);
    localparam logic signed [c_EW-1:0] c_ONE      = c_EW'(1);
    localparam logic [DW-1:0]          c_QNAN     = DW'(canon_nan(EXP_W, MAN_W));

    state_t                  r_state, w_next;
    logic [c_CNT_W-1:0]      r_cnt;
    logic                    r_sign;
    logic signed [c_EW-1:0]  r_exp;
    fp_class_t               r_cls_a, r_cls_b;
    logic [MAN_W:0]          r_mb;
    logic [MAN_W+1:0]        r_rem;
    logic [MAN_W+2:0]        r_q;
    logic [DW-1:0]           r_out_q;

    logic                    w_sign_a, w_sign_b;
    logic [EXP_W-1:0]        w_exp_a, w_exp_b;
    logic [MAN_W:0]          w_sig_a, w_sig_b;
    fp_class_t               w_cls_a, w_cls_b;

    fdiv_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
        .i_op(in_a), .o_sign(w_sign_a), .o_exp(w_exp_a), .o_sig(w_sig_a), .o_cls(w_cls_a)
    );
    fdiv_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
        .i_op(in_b), .o_sign(w_sign_b), .o_exp(w_exp_b), .o_sig(w_sig_b), .o_cls(w_cls_b)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid) w_next = ST_DIV;
            ST_DIV:   if (r_cnt == c_CNT_LAST) w_next = ST_ROUND;
            ST_ROUND: w_next = ST_DONE;
            ST_DONE:  if (out_ready) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_DONE);
    end

    assign out_q = r_out_q;

    // One restoring step: compare, conditionally subtract, shift.
    logic             w_ge;
    logic [MAN_W+1:0] w_sub;
    assign w_ge  = (r_rem >= {1'b0, r_mb});
    assign w_sub = r_rem - {1'b0, r_mb};

    logic                   w_norm, w_g, w_s, w_inc, w_nan_case;
    logic [MAN_W:0]         w_keep;
    logic [MAN_W+1:0]       w_rsig;
    logic [MAN_W-1:0]       w_frac;
    logic signed [c_EW-1:0] w_e1, w_e2;
    logic [DW-1:0]          w_res;

    assign w_norm = r_q[MAN_W+2];
    assign w_keep = w_norm ? r_q[MAN_W+2:2] : r_q[MAN_W+1:1];
    assign w_g    = w_norm ? r_q[1] : r_q[0];
    assign w_s    = (w_norm & r_q[0]) | (|r_rem);
    assign w_e1   = w_norm ? r_exp : r_exp - c_ONE;
    assign w_inc  = w_g & (w_keep[0] | w_s);
    assign w_rsig = {1'b0, w_keep} + {{(MAN_W+1){1'b0}}, w_inc};
    assign w_frac = w_rsig[MAN_W+1] ? w_rsig[MAN_W:1] : w_rsig[MAN_W-1:0];
    assign w_e2   = w_rsig[MAN_W+1] ? w_e1 + c_ONE : w_e1;

    assign w_nan_case = (r_cls_a == CLS_NAN) || (r_cls_b == CLS_NAN)
                     || (r_cls_a == CLS_ZERO && r_cls_b == CLS_ZERO)
                     || (r_cls_a == CLS_INF  && r_cls_b == CLS_INF);

`ifdef FDIV_ITER_FLAGS_EN
    logic [4:0] w_flags, r_flags;
`endif

    always_comb begin
        w_res = {r_sign, w_e2[EXP_W-1:0], w_frac};
`ifdef FDIV_ITER_FLAGS_EN
        w_flags               = '0;
        w_flags[FLAG_INEXACT] = w_g | w_s;
`endif
        if (w_nan_case) begin
            w_res = c_QNAN;
`ifdef FDIV_ITER_FLAGS_EN
            w_flags               = '0;
            w_flags[FLAG_INVALID] = 1'b1;
`endif
        end else if (r_cls_a == CLS_NORM && r_cls_b == CLS_ZERO) begin
            w_res = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FDIV_ITER_FLAGS_EN
            w_flags            = '0;
            w_flags[FLAG_DIV0] = 1'b1;
`endif
        end else if (r_cls_a == CLS_INF) begin
            w_res = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FDIV_ITER_FLAGS_EN
            w_flags = '0;
`endif
        end else if (r_cls_a == CLS_ZERO || r_cls_b == CLS_INF) begin
            w_res = {r_sign, {(DW-1){1'b0}}};
`ifdef FDIV_ITER_FLAGS_EN
            w_flags = '0;
`endif
        end else if (w_e2 >= c_EXP_MAX) begin
            w_res = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FDIV_ITER_FLAGS_EN
            w_flags[FLAG_OVERFLOW] = 1'b1;
            w_flags[FLAG_INEXACT]  = 1'b1;
`endif
        end else if (w_e2[c_EW-1] || w_e2 == '0) begin
            w_res = {r_sign, {(DW-1){1'b0}}};
`ifdef FDIV_ITER_FLAGS_EN
            w_flags[FLAG_UNDERFLW] = 1'b1;
            w_flags[FLAG_INEXACT]  = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_sign  <= 1'b0;
            r_exp   <= '0;
            r_cls_a <= CLS_ZERO;
            r_cls_b <= CLS_ZERO;
            r_mb    <= '0;
            r_rem   <= '0;
            r_q     <= '0;
            r_out_q <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (in_valid) begin
                    r_cnt   <= '0;
                    r_sign  <= w_sign_a ^ w_sign_b;
                    r_exp   <= $signed({2'b00, w_exp_a}) - $signed({2'b00, w_exp_b}) + c_BIAS;
                    r_cls_a <= w_cls_a;
                    r_cls_b <= w_cls_b;
                    r_mb    <= w_sig_b;
                    r_rem   <= {1'b0, w_sig_a};
                    r_q     <= '0;
                end
                ST_DIV: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_q   <= {r_q[MAN_W+1:0], w_ge};
                    r_rem <= w_ge ? {w_sub[MAN_W:0], 1'b0} : {r_rem[MAN_W:0], 1'b0};
                end
                ST_ROUND: r_out_q <= w_res;
                default: ;
            endcase
        end
    end

`ifdef FDIV_ITER_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst)                     r_flags <= '0;
        else if (r_state == ST_ROUND) r_flags <= w_flags;
    end
    assign out_flags = r_flags;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fdiv_iter.sv
// ============================================================================
// Module      : tb_fdiv_iter
// Description : Scoreboard bench for fdiv_iter (FP32) with an exact-ratio model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fdiv_iter;

    localparam int c_LAT = 23 + 4;

    typedef struct {
        logic [31:0] q;
        logic [4:0]  f;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_q;
`ifdef FDIV_ITER_FLAGS_EN
    logic [4:0]  out_flags;
`endif

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   bp_rand = 1'b0;
    exp_t exp_q[$];
    int   lat_q[$];

    fdiv_iter #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q)
`ifdef FDIV_ITER_FLAGS_EN
        ,
        .out_flags (out_flags)
`endif
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference: exact integer quotient scaled to 24 significant bits,
    // rounded by comparing twice the remainder against the divisor.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t   r;
        int     ea, eb, e, sh;
        longint ma, mb, num, qi, rm;
        bit     s, za, zb, ia, ib, na, nb;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 0);
        ib = (eb == 255) && (b[22:0] == 0);
        na = (ea == 255) && (a[22:0] != 0);
        nb = (eb == 255) && (b[22:0] != 0);
        s  = a[31] ^ b[31];
        r.f = 5'b0;
        if (na || nb || (za && zb) || (ia && ib)) begin
            r.q = 32'h7FC00000; r.f = 5'b10000; return r;
        end
        if (zb && !ia) begin r.q = {s, 8'hFF, 23'h0}; r.f = 5'b01000; return r; end
        if (ia)        begin r.q = {s, 8'hFF, 23'h0}; return r; end
        if (za || ib)  begin r.q = {s, 31'h0}; return r; end
        ma = longint'({1'b1, a[22:0]});
        mb = longint'({1'b1, b[22:0]});
        e  = ea - eb + 127;
        sh = 23;
        if (ma < mb) begin sh = 24; e--; end
        num = ma << sh;
        qi  = num / mb;
        rm  = num % mb;
        if ((2 * rm > mb) || ((2 * rm == mb) && qi[0])) qi++;
        if (qi == (longint'(1) << 24)) begin qi = qi >> 1; e++; end
        if (e >= 255) begin
            r.q = {s, 8'hFF, 23'h0}; r.f = 5'b00101;
        end else if (e <= 0) begin
            r.q = {s, 31'h0}; r.f = 5'b00011;
        end else begin
            r.q = {s, 8'(e), qi[22:0]}; r.f = {4'b0, rm != 0};
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] f;
        int sel;
        sel = $urandom_range(0, 15);
        f   = 23'($urandom);
        if (sel == 0)      e = 8'h00;
        else if (sel == 1) e = 8'hFF;
        else if (sel <= 3) e = 8'($urandom_range(1, 254));
        else               e = 8'($urandom_range(100, 154));
        if ($urandom_range(0, 7) == 0) f = '0;
        return {1'($urandom), e, f};
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [4:0] f);
        int   t = 0;
        exp_t ex;
        @(posedge clk); #1;
        while (!in_ready && t < 300) begin @(posedge clk); #1; t++; end
        if (!in_ready) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout: in_ready %b, required 1", in_ready);
            return;
        end
        ex.q = q; ex.f = f;
        exp_q.push_back(ex);
        in_a = a; in_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic issue_rand();
        logic [31:0] a, b;
        exp_t ex;
        a  = rand_op();
        b  = rand_op();
        ex = model(a, b);
        issue(a, b, ex.q, ex.f);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin @(posedge clk); t++; end
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL drain_timeout: %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: scoreboard pop, latency, hold stability and release behaviour.
    initial begin
        logic        prev_valid;
        logic        chk_idle;
        logic [31:0] held;
        exp_t        ex;
        int          acc;
        prev_valid = 1'b0;
        chk_idle   = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                lat_q.delete(); prev_valid = 1'b0; chk_idle = 1'b0;
                continue;
            end
            if (chk_idle) begin
                chk("release_in_ready", 64'(in_ready), 64'd1);
                chk("release_out_valid", 64'(out_valid), 64'd0);
                chk_idle = 1'b0;
            end
            if (in_valid && in_ready) lat_q.push_back(cyc + 1);
            if (out_valid) begin
                if (!prev_valid) begin
                    held = out_q;
                    if (lat_q.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL spurious_valid: out_q %h with no accepted op", out_q);
                    end else begin
                        acc = lat_q.pop_front();
                        chk("latency", 64'(cyc - acc), 64'(c_LAT));
                    end
                end else begin
                    chk("hold_out_q", 64'(out_q), 64'(held));
                    chk("hold_in_ready", 64'(in_ready), 64'd0);
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL unexpected_output: out_q %h, scoreboard empty", out_q);
                    end else begin
                        ex = exp_q.pop_front();
                        chk("out_q", 64'(out_q), 64'(ex.q));
`ifdef FDIV_ITER_FLAGS_EN
                        chk("out_flags", 64'(out_flags), 64'(ex.f));
`endif
                    end
                    chk_idle = 1'b1;
                end
            end
            prev_valid = out_valid && !out_ready;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_q", 64'(out_q), 64'd0);
        rst = 1'b0;

        issue(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000);
        issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001);
        issue(32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000);
        issue(32'h00000000, 32'h80000000, 32'h7FC00000, 5'b10000);
        issue(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b10000);
        issue(32'h7F000000, 32'h3E800000, 32'h7F800000, 5'b00101);
        issue(32'h00800000, 32'h40000000, 32'h00000000, 5'b00011);
        issue(32'hC0000000, 32'h3F800000, 32'hC0000000, 5'b00000);
        drain();

        // Backpressure: hold the result for ten cycles, then release.
        out_ready = 1'b0;
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000);
        t = 0;
        while (!out_valid && t < 100) begin @(posedge clk); #1; t++; end
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001);
        issue(32'hC0000000, 32'h3F800000, 32'hC0000000, 5'b00000);
        drain();

        // Reset in the middle of the iteration discards the operation.
        issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_in_ready", 64'(in_ready), 64'd1);
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000);
        drain();

        bp_rand = 1'b1;
        for (int i = 0; i < 200; i++) issue_rand();
        drain();
        bp_rand = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
